// File: rtl/ray_dir_gen.sv
// Per-pixel camera ray direction generator.
// Walks the frame in raster order and emits one direction per accepted cycle:
// (float(cx - H_RES/2), float(V_RES/2 - cy), FOCAL).
// A tag line of TAG_LAT stages carries pixel coordinates and the last-pixel flag
// so they line up with the downstream normalize result.
module ray_dir_gen #(
  parameter int          H_RES   = 640,
  parameter int          V_RES   = 480,
  parameter logic [26:0] FOCAL   = 27'h2000000,
  parameter int          TAG_LAT = 9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_ready,
  output logic [26:0] o_dir_x,
  output logic [26:0] o_dir_y,
  output logic [26:0] o_dir_z,
  output logic        o_valid,
  output logic [9:0]  o_tag_px_x,
  output logic [9:0]  o_tag_px_y,
  output logic        o_tag_valid,
  output logic        o_tag_last,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam logic [9:0]  H_MAX  = 10'(H_RES - 1);
  localparam logic [9:0]  V_MAX  = 10'(V_RES - 1);
  localparam logic [10:0] H_HALF = 11'(H_RES / 2);
  localparam logic [10:0] V_HALF = 11'(V_RES / 2);
  localparam int          TAG_W  = 22;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cx_q, cx_d, cy_q, cy_d;
  logic [26:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d, dir_z_q, dir_z_d;
  logic        valid_q, valid_d, last_q, last_d;
  logic [9:0]  px_x_q, px_x_d, px_y_q, px_y_d;
  logic [TAG_W-1:0] tag_q [TAG_LAT];
  logic [TAG_W-1:0] tag_d [TAG_LAT];

  logic        emit;
  logic        at_last;
  logic [10:0] x_off, y_off;
  logic        frame_done;

  // Exact signed-int to float: magnitude, leading-one position, and a
  // left shift that pushes the hidden bit just past the 18-bit mantissa.
  function automatic logic [26:0] int_to_float(input logic [10:0] v);
    logic [10:0] mag;
    logic [3:0]  msb;
    logic [4:0]  sh;
    logic [17:0] mant;
    logic [7:0]  expo;
    logic [26:0] res;
    mag = v[10] ? (~v + 11'd1) : v;
    msb = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (mag[i]) msb = 4'(i);
    end
    sh   = 5'd18 - {1'b0, msb};
    mant = {7'd0, mag} << sh;
    expo = 8'd127 + {4'd0, msb};
    res  = (mag == 11'd0) ? 27'h0 : {v[10], expo, mant};
    return res;
  endfunction

  assign emit    = (state_q == S_RUN) && i_ready;
  assign at_last = (cx_q == H_MAX) && (cy_q == V_MAX);
  assign x_off   = {1'b0, cx_q} - H_HALF;
  assign y_off   = V_HALF - {1'b0, cy_q};

  // Frame state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start only from idle, drain after the last pixel, idle once its tag exits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (emit && at_last) state_d = S_DRAIN;
      S_DRAIN: if (frame_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy = (state_q != S_IDLE);
  end

  // Counters and emitted direction: load on accept, hold otherwise.
  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    dir_z_d = dir_z_q;
    px_x_d  = px_x_q;
    px_y_d  = px_y_q;
    last_d  = last_q;
    valid_d = 1'b0;
    if ((state_q == S_IDLE) && i_start) begin
      cx_d = 10'd0;
      cy_d = 10'd0;
    end
    if (emit) begin
      dir_x_d = int_to_float(x_off);
      dir_y_d = int_to_float(y_off);
      dir_z_d = FOCAL;
      px_x_d  = cx_q;
      px_y_d  = cy_q;
      last_d  = at_last;
      valid_d = 1'b1;
      if (at_last) begin
        cx_d = 10'd0;
        cy_d = 10'd0;
      end else if (cx_q == H_MAX) begin
        cx_d = 10'd0;
        cy_d = cy_q + 10'd1;
      end else begin
        cx_d = cx_q + 10'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cx_q    <= 10'd0;
      cy_q    <= 10'd0;
      dir_x_q <= 27'h0;
      dir_y_q <= 27'h0;
      dir_z_q <= 27'h0;
      px_x_q  <= 10'd0;
      px_y_q  <= 10'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      dir_z_q <= dir_z_d;
      px_x_q  <= px_x_d;
      px_y_q  <= px_y_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Tag line input is the output-cycle view of the pixel; each stage adds one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < TAG_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_d[gi] = {valid_q, last_q, px_x_q, px_y_q};
      end else begin : g_body
        assign tag_d[gi] = tag_q[gi-1];
      end
    end
  endgenerate

  // Tag shift register; reset clears every stage so nothing stale emerges.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < TAG_LAT; i++) begin
      if (i_rst) tag_q[i] <= '0;
      else       tag_q[i] <= tag_d[i];
    end
  end

  assign o_dir_x      = dir_x_q;
  assign o_dir_y      = dir_y_q;
  assign o_dir_z      = dir_z_q;
  assign o_valid      = valid_q;
  assign o_tag_valid  = tag_q[TAG_LAT-1][21];
  assign o_tag_last   = tag_q[TAG_LAT-1][20];
  assign o_tag_px_x   = tag_q[TAG_LAT-1][19:10];
  assign o_tag_px_y   = tag_q[TAG_LAT-1][9:0];
  assign frame_done   = o_tag_valid && o_tag_last;
  assign o_frame_done = frame_done;

endmodule

// File: tb/tb_ray_dir_gen.sv
// Randomized bench for ray_dir_gen: two instances (default geometry and a 4x2 frame),
// each checked every cycle against a pixel-index model with a tag history buffer.
module tb_ray_dir_gen;

  typedef struct packed {
    logic       v;
    logic       last;
    logic [9:0] px;
    logic [9:0] py;
  } tup_t;

  localparam logic [26:0] FOC = 27'h2000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        start_s [2];
  logic        ready_s [2];
  logic [26:0] g_x [2], g_y [2], g_z [2];
  logic        g_valid [2], g_tv [2], g_tl [2], g_busy [2], g_done [2];
  logic [9:0]  g_tx [2], g_ty [2];

  ray_dir_gen u_a (
    .i_clk(clk), .i_rst(rst_s[0]), .i_start(start_s[0]), .i_ready(ready_s[0]),
    .o_dir_x(g_x[0]), .o_dir_y(g_y[0]), .o_dir_z(g_z[0]), .o_valid(g_valid[0]),
    .o_tag_px_x(g_tx[0]), .o_tag_px_y(g_ty[0]), .o_tag_valid(g_tv[0]),
    .o_tag_last(g_tl[0]), .o_busy(g_busy[0]), .o_frame_done(g_done[0])
  );

  ray_dir_gen #(.H_RES(4), .V_RES(2), .TAG_LAT(3)) u_b (
    .i_clk(clk), .i_rst(rst_s[1]), .i_start(start_s[1]), .i_ready(ready_s[1]),
    .o_dir_x(g_x[1]), .o_dir_y(g_y[1]), .o_dir_z(g_z[1]), .o_valid(g_valid[1]),
    .o_tag_px_x(g_tx[1]), .o_tag_px_y(g_ty[1]), .o_tag_valid(g_tv[1]),
    .o_tag_last(g_tl[1]), .o_busy(g_busy[1]), .o_frame_done(g_done[1])
  );

  int HR [2] = '{640, 4};
  int VR [2] = '{480, 2};
  int TL [2] = '{9, 3};

  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 0;
  bit          seen321 = 0;

  int          m_state [2];
  int          m_n [2];
  int          m_cyc [2];
  int          m_acc [2];
  int          done_cnt [2];
  logic        m_valid [2], m_last [2];
  logic [26:0] m_x [2], m_y [2], m_z [2];
  int          m_px [2], m_py [2];
  tup_t        hist [2][64];

  // Reference float of an integer, from the format's definition.
  function automatic logic [26:0] flt(int v);
    int a, e;
    logic [26:0] r;
    if (v == 0) return 27'h0;
    a = (v < 0) ? -v : v;
    e = 0;
    while ((1 << (e + 1)) <= a) e++;
    r[26]    = (v < 0);
    r[25:18] = 8'(127 + e);
    r[17:0]  = 18'((a - (1 << e)) * (1 << (18 - e)));
    return r;
  endfunction

  function automatic tup_t tag_now(int k);
    return hist[k][((m_cyc[k] - TL[k]) % 64 + 64) % 64];
  endfunction

  task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, k, $time, got, exp);
    end
  endtask

  // Model: advance one clock edge given the inputs seen at that edge.
  task automatic step(int k, logic rst, logic st, logic rd);
    tup_t tg, cur;
    int h, v;
    h = HR[k];
    v = VR[k];
    if (rst) begin
      m_state[k] = 0; m_n[k] = 0; m_valid[k] = 0; m_last[k] = 0;
      m_x[k] = 0; m_y[k] = 0; m_z[k] = 0; m_px[k] = 0; m_py[k] = 0;
      for (int i = 0; i < 64; i++) hist[k][i] = '0;
    end else begin
      tg       = tag_now(k);
      cur.v    = m_valid[k];
      cur.last = m_last[k];
      cur.px   = 10'(m_px[k]);
      cur.py   = 10'(m_py[k]);
      hist[k][m_cyc[k] % 64] = cur;
      m_cyc[k]++;
      m_valid[k] = 0;
      case (m_state[k])
        0: if (st) begin m_state[k] = 1; m_n[k] = 0; m_acc[k]++; end
        1: if (rd) begin
          m_px[k]    = m_n[k] % h;
          m_py[k]    = m_n[k] / h;
          m_x[k]     = flt(m_px[k] - h / 2);
          m_y[k]     = flt(v / 2 - m_py[k]);
          m_z[k]     = FOC;
          m_valid[k] = 1;
          m_last[k]  = (m_n[k] == h * v - 1);
          m_n[k]++;
          if (m_last[k]) m_state[k] = 2;
        end
        default: if (tg.v && tg.last) m_state[k] = 0;
      endcase
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) step(k, rst_s[k], start_s[k], ready_s[k]);
  end

  // Compare every DUT output against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        tup_t tg;
        tg = tag_now(k);
        chk("valid", k, 32'(g_valid[k]), 32'(m_valid[k]));
        chk("dir_x", k, 32'(g_x[k]), 32'(m_x[k]));
        chk("dir_y", k, 32'(g_y[k]), 32'(m_y[k]));
        chk("dir_z", k, 32'(g_z[k]), 32'(m_z[k]));
        chk("tag_valid", k, 32'(g_tv[k]), 32'(tg.v));
        chk("busy", k, 32'(g_busy[k]), 32'(m_state[k] != 0));
        chk("frame_done", k, 32'(g_done[k]), 32'(tg.v && tg.last));
        if (tg.v) begin
          chk("tag_px_x", k, 32'(g_tx[k]), 32'(tg.px));
          chk("tag_px_y", k, 32'(g_ty[k]), 32'(tg.py));
          chk("tag_last", k, 32'(g_tl[k]), 32'(tg.last));
        end
        if (m_valid[k]) begin
          $display("[TB] dut%0d t=%0t pixel (%0d,%0d) x=%h y=%h z=%h",
                   k, $time, m_px[k], m_py[k], g_x[k], g_y[k], g_z[k]);
        end
        if (g_done[k] === 1'b1) done_cnt[k]++;
      end
      // Hand-computed anchors for the default geometry and the small frame.
      if (m_valid[0] && m_n[0] == 1) begin
        chk("first_x", 0, 32'(g_x[0]), 32'h61D0000);
        chk("first_y", 0, 32'(g_y[0]), 32'h21B8000);
        chk("first_z", 0, 32'(g_z[0]), 32'h2000000);
      end
      if (m_valid[0] && m_px[0] == 321 && m_py[0] == 0) begin
        seen321 = 1;
        chk("pix321_x", 0, 32'(g_x[0]), 32'h1FC0000);
      end
      if (m_valid[1] && m_px[1] == 2 && m_py[1] == 1) begin
        chk("center_x", 1, 32'(g_x[1]), 32'h0);
        chk("center_y", 1, 32'(g_y[1]), 32'h0);
      end
      if (g_tv[1] === 1'b1 && g_tx[1] == 10'd3 && g_ty[1] == 10'd1)
        chk("done_at_last_tag", 1, 32'(g_done[1]), 32'h1);
    end
  end

  task automatic reset_and_watch(int k);
    int tv;
    rst_s[k] = 1; start_s[k] = 0;
    @(negedge clk);
    rst_s[k] = 0;
    tv = 0;
    repeat (15) begin
      @(negedge clk);
      if (g_tv[k] === 1'b1) tv++;
    end
    chk("stale_tag_after_rst", k, tv, 0);
  endtask

  // mode 0: ready always high; 1: ready toggles; 2: random ready plus random start pulses.
  task automatic run_frame(int k, int mode, int budget);
    int nv;
    bit got;
    nv = 0;
    got = 0;
    start_s[k] = 1; ready_s[k] = 1;
    @(negedge clk);
    start_s[k] = 0;
    for (int c = 0; c < budget && !got; c++) begin
      case (mode)
        0: ready_s[k] = 1;
        1: ready_s[k] = ~ready_s[k];
        default: begin
          ready_s[k] = ($urandom % 2) != 0;
          start_s[k] = ($urandom % 5) == 0;
        end
      endcase
      @(negedge clk);
      if (g_valid[k] === 1'b1) nv++;
      if (g_done[k] === 1'b1) got = 1;
    end
    chk("frame_done_seen", k, 32'(got), 32'h1);
    if (mode < 2) chk("valid_count", k, nv, 8);
    @(negedge clk);
  endtask

  initial begin
    int acc0, dn0;
    bit idle;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1; start_s[k] = 0; ready_s[k] = 0;
    end
    chk("model_m320", 0, 32'(flt(-320)), 32'h61D0000);
    chk("model_240", 0, 32'(flt(240)), 32'h21B8000);
    chk("model_0", 0, 32'(flt(0)), 32'h0);
    chk("model_1", 0, 32'(flt(1)), 32'h1FC0000);
    chk("model_512", 0, 32'(flt(512)), 32'h2200000);
    repeat (3) @(negedge clk);
    chk_en = 1;
    rst_s[0] = 0; rst_s[1] = 0;
    @(negedge clk);

    // Default geometry: partial frame with random bubbles, then mid-frame resets.
    start_s[0] = 1; ready_s[0] = 1;
    @(negedge clk);
    start_s[0] = 0;
    for (int i = 0; i < 700; i++) begin
      ready_s[0] = ($urandom % 8) != 0;
      @(negedge clk);
    end
    chk("pix321_reached", 0, 32'(seen321), 32'h1);
    reset_and_watch(0);
    start_s[0] = 1; ready_s[0] = 1;
    @(negedge clk);
    start_s[0] = 0;
    repeat (5) @(negedge clk);
    reset_and_watch(0);
    start_s[0] = 1; ready_s[0] = 1;
    @(negedge clk);
    start_s[0] = 0;
    for (int i = 0; i < 40; i++) begin
      ready_s[0] = ($urandom % 2) != 0;
      @(negedge clk);
    end
    reset_and_watch(0);

    // Small frame: full frames with steady, toggling and random ready.
    acc0 = m_acc[1];
    dn0  = done_cnt[1];
    run_frame(1, 0, 60);
    run_frame(1, 1, 60);
    for (int i = 0; i < 8; i++) run_frame(1, 2, 120);
    start_s[1] = 0;
    idle = 0;
    for (int c = 0; c < 200 && !idle; c++) begin
      ready_s[1] = ($urandom % 2) != 0;
      @(negedge clk);
      if (g_busy[1] === 1'b0) idle = 1;
    end
    chk("drain_to_idle", 1, 32'(idle), 32'h1);
    repeat (2) @(negedge clk);
    chk("frame_count", 1, done_cnt[1] - dn0, m_acc[1] - acc0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ray_dir_gen.md
RAY_DIR_GEN -- requirements
Module: ray_dir_gen

Interface
REQ-001 SHALL have parameter H_RES, default 640, horizontal pixel count (even, 2..1024).
REQ-002 SHALL have parameter V_RES, default 480, vertical pixel count (even, 2..1024).
REQ-003 SHALL have parameter FOCAL, default 27'h2000000 (+2.0), 27-bit float z component of every ray.
REQ-004 SHALL have parameter TAG_LAT, default 9, tag delay in cycles, matching the downstream vector-normalize latency (range 1..32).
REQ-005 SHALL have port i_clk, input, 1, sole clock; all logic is sampled on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, reset that is synchronous and active-high.
REQ-007 SHALL have port i_start, input, 1, pulse that begins one frame.
REQ-008 SHALL have port i_ready, input, 1, downstream accepts one direction per cycle when high.
REQ-009 SHALL have ports o_dir_x, o_dir_y, o_dir_z, output, 27 each, ray direction floats.
REQ-010 SHALL have port o_valid, output, 1, which qualifies o_dir_*.
REQ-011 SHALL have ports o_tag_px_x and o_tag_px_y, output, 10 each, pixel coordinates delayed by TAG_LAT cycles.
REQ-012 SHALL have ports o_tag_valid and o_tag_last, output, 1 each, delayed valid and delayed last-pixel flag.
REQ-013 SHALL have port o_busy, output, 1, high in states RUN and DRAIN.
REQ-014 SHALL have port o_frame_done, output, 1, one-cycle pulse at frame completion.

Function
REQ-015 Float format SHALL be: [26] sign, [25:18] exponent with bias 127, [17:0] mantissa with hidden 1; zero is encoded as 27'h0.
REQ-016 State machine SHALL be IDLE -> RUN on i_start; RUN -> DRAIN when the last pixel is emitted; DRAIN -> IDLE in the o_frame_done cycle.
REQ-017 Pixel counters cx (0..H_RES-1) and cy (0..V_RES-1) SHALL be raster order, cx fastest, and SHALL be zero on entry to RUN.
REQ-018 Emit rule: an edge with state=RUN and i_ready=1 SHALL load o_dir_* from (cx,cy), set o_valid=1, and advance the counters; otherwise o_valid SHALL be 0 on the next cycle, o_dir_* SHALL hold, and the counters SHALL hold.
REQ-019 The block SHALL NOT hold data waiting on i_ready, and SHALL NOT backpressure; i_ready low inserts bubbles.
REQ-020 Direction fields SHALL be: x_off = cx - H_RES/2 and y_off = V_RES/2 - cy, each 11-bit signed.
REQ-021 Direction outputs SHALL be: o_dir_x = float(x_off), o_dir_y = float(y_off), o_dir_z = FOCAL.
REQ-022 Int-to-float conversion SHALL be exact (|v| <= 512 fits in the mantissa), using a leading-one detect, exponent = 127 + msb index, and a mantissa left-aligned with the hidden bit removed.
REQ-023 Latency SHALL be 1 cycle from the accepting edge to o_valid.
REQ-024 Tag line: o_tag_valid, o_tag_px_x/y and o_tag_last SHALL equal the o_valid-cycle values of valid, cx, cy and last delayed exactly TAG_LAT cycles; bubbles propagate as tag_valid=0.
REQ-025 last SHALL be 1 only for pixel (H_RES-1, V_RES-1).
REQ-026 o_frame_done SHALL be 1 exactly in the cycle o_tag_valid && o_tag_last.
REQ-027 o_busy SHALL fall in the cycle after o_frame_done.
REQ-028 i_start SHALL be ignored in RUN and DRAIN.
REQ-029 i_start coincident with o_frame_done SHALL be ignored.
REQ-030 Counter wrap: cx = H_RES-1 SHALL advance to cx=0, cy+1; at the last pixel, advancing SHALL enter DRAIN, with counters don't-care.

Reset
REQ-031 i_rst SHALL override all other inputs, including mid-frame and during DRAIN.
REQ-032 On the edge where i_rst=1, state SHALL become IDLE and cx, cy SHALL become 0.
REQ-033 On the edge where i_rst=1, o_valid, o_tag_valid, o_tag_last, o_busy and o_frame_done SHALL become 0.
REQ-034 On the edge where i_rst=1, o_dir_* and o_tag_px_* SHALL become 0, and every tag-line stage SHALL be cleared, so no stale tag emerges after reset.

Verification
REQ-035 Defaults, i_start, i_ready=1 -> first o_valid has o_dir_x=27'h61D0000 (-320), o_dir_y=27'h21B8000 (+240), o_dir_z=27'h2000000.
REQ-036 Defaults, pixel (320,240) -> o_dir_x=o_dir_y=27'h0; pixel (321,0) -> o_dir_x=27'h1FC0000 (+1.0).
REQ-037 H_RES=4, V_RES=2, TAG_LAT=3, i_ready=1 -> exactly 8 valids on consecutive cycles; tags are the same sequence 3 cycles later; o_frame_done coincides with tag (3,1); o_busy falls next cycle.
REQ-038 As REQ-037 with i_ready toggling 1,0,1,0 -> counters hold on 0 cycles; tag bubbles are aligned; 8 valids total; no duplicates or skips.
REQ-039 i_rst asserted after 5 pixels, then i_start -> no tag_valid from the old frame appears; the new frame starts at (0,0).
REQ-040 i_start pulsed during RUN and DRAIN -> no effect; the frame count of o_frame_done pulses equals the i_start pulses accepted in IDLE.
